// File: rtl/demux_rr_arbiter.sv
// demux_rr_arbiter
// Round-robin arbiter that owns the select input of a 4-way demux. It grants one of four
// requesters at a time and bounds each grant to HOLD_MAX cycles. Every release is followed
// by a one-cycle all-zero GAP, so the demux always breaks before it makes.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   req      request lines, bit i = requester i (level-sensitive)
//   done     current holder finished (only looked at while granting)
//   grant    one-hot grant, zero when no grant is active
//   select   demux lane index (encoded grant while granting, otherwise held)
//   busy     high while granting or in the gap cycle
//   timeout  one-cycle pulse in the gap that follows a hold-limit revocation
module demux_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

  state_e     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] select_q, select_d;
  logic [1:0] last_q, last_d;
  logic [7:0] hold_q, hold_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;

  logic [1:0] pick_idx;
  logic       pick_valid;
  logic [1:0] cand;

  // Scan last+1 .. last+4 (mod 4); the last-served requester is checked last.
  always_comb begin
    pick_idx   = last_q;
    pick_valid = 1'b0;
    cand       = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  logic exit_done, exit_drop, exit_hold;

  assign exit_done = done;
  assign exit_drop = !req[select_q];
  assign exit_hold = (hold_q >= HoldLast);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    select_d  = select_q;
    last_d    = last_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d  = StGrant;
          grant_d  = 4'b0001 << pick_idx;
          select_d = pick_idx;
          last_d   = pick_idx;
          hold_d   = 8'd0;
          busy_d   = 1'b1;
        end
      end
      StGrant: begin
        if (exit_done || exit_drop || exit_hold) begin
          state_d   = StGap;
          grant_d   = 4'b0000;
          // Only a pure hold-limit revocation is reported.
          timeout_d = !exit_done && !exit_drop;
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end
      StGap: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      grant_q   <= 4'b0000;
      select_q  <= 2'd0;
      last_q    <= 2'd3;
      hold_q    <= 8'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      select_q  <= select_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign select  = select_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_demux_rr_arbiter.sv
// Self-checking bench for demux_rr_arbiter: a transaction-level model (current owner,
// cycles served, gap pending) is compared against the DUT on every falling edge, and
// directed scenarios pin the model with hand-computed literals.
module tb_demux_rr_arbiter;

  localparam int HM = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] select;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  demux_rr_arbiter #(.HOLD_MAX(HM)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .done   (done),
    .grant  (grant),
    .select (select),
    .busy   (busy),
    .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the demux, how many cycles it has been served, whether a gap is due.
  int         m_owner;
  int         m_held;
  int         m_last;
  int         m_sel;
  bit         m_gap;
  bit         m_to;
  logic [3:0] m_grant;

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 3;
    m_sel   = 0;
    m_gap   = 1'b0;
    m_to    = 1'b0;
  endtask

  // Advance by one clock using the inputs that the next rising edge will sample.
  task automatic model_step();
    int c;
    if (m_gap) begin
      m_gap = 1'b0;
      m_to  = 1'b0;
    end else if (m_owner >= 0) begin
      m_held++;
      if (done || !req[m_owner] || m_held == HM) begin
        m_to    = !done && req[m_owner];
        m_owner = -1;
        m_gap   = 1'b1;
      end
    end else if (req != 4'b0000) begin
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (m_owner < 0 && req[c]) m_owner = c;
      end
      m_last = m_owner;
      m_sel  = m_owner;
      m_held = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      m_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      chk("model_grant", grant, m_grant);
      chk("model_select", select, m_sel);
      chk("model_busy", busy, (m_owner >= 0) || m_gap);
      chk("model_timeout", timeout, m_to);
      chk("onehot", $countones(grant) <= 1, 1);
      if (rst_n) model_step();
    end
  end

  // From a point just after an edge, wait for a grant; count the zero-grant cycles seen.
  task automatic next_grant(input logic [3:0] exp, input int exp_zero);
    int z = 0;
    while (grant == 4'b0000 && z < 40) begin
      z++;
      @(posedge clk);
      #1;
    end
    chk("next_grant", grant, exp);
    chk("zero_cycles", z, exp_zero);
  endtask

  // Assert done in cycle n of the current grant and check the release.
  task automatic pulse_done(input int n);
    repeat (n - 1) begin
      @(posedge clk);
      #1;
    end
    done = 1'b1;
    @(posedge clk);
    #1;
    done = 1'b0;
    chk("release_grant", grant, 4'b0000);
  endtask

  logic [3:0] rot_seq [4];
  int         g;

  initial begin
    rot_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", grant, 4'b0000);
    chk("rst_select", select, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_grant", grant, 4'b0001);
    chk("first_select", select, 2'd0);
    chk("first_busy", busy, 1'b1);
    chk("first_timeout", timeout, 1'b0);

    // Rotation with done in the third cycle of each grant.
    for (int i = 0; i < 4; i++) begin
      pulse_done(3);
      next_grant(rot_seq[i], 2);
    end

    // Hold limit with a single steady requester.
    pulse_done(3);
    req = 4'b0100;
    next_grant(4'b0100, 2);
    g = 0;
    while (grant == 4'b0100 && g < 40) begin
      g++;
      @(posedge clk);
      #1;
    end
    chk("hold_len", g, HM);
    chk("hold_timeout", timeout, 1'b1);
    chk("hold_busy", busy, 1'b1);
    next_grant(4'b0100, 2);
    chk("hold_regrant_select", select, 2'd2);

    // Request drop, then skip to requester 3.
    req = 4'b1010;
    @(posedge clk);
    #1;
    chk("drop2_grant", grant, 4'b0000);
    chk("drop2_timeout", timeout, 1'b0);
    next_grant(4'b1000, 2);
    pulse_done(1);
    next_grant(4'b0010, 2);
    req = 4'b1000;
    @(posedge clk);
    #1;
    chk("drop1_grant", grant, 4'b0000);
    chk("drop1_timeout", timeout, 1'b0);
    next_grant(4'b1000, 2);
    chk("skip_select", select, 2'b11);

    // done coincides with the last allowed cycle.
    repeat (HM - 1) begin
      @(posedge clk);
      #1;
    end
    chk("coin_before", grant, 4'b1000);
    done = 1'b1;
    @(posedge clk);
    #1;
    done = 1'b0;
    chk("coin_grant", grant, 4'b0000);
    chk("coin_timeout", timeout, 1'b0);

    // Asynchronous reset in the middle of a grant to requester 1.
    next_grant(4'b1000, 2);
    req = 4'b0010;
    @(posedge clk);
    #1;
    next_grant(4'b0010, 2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_grant", grant, 4'b0000);
    chk("async_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rearm_grant", grant, 4'b0010);
    chk("rearm_select", select, 2'd1);

    // Drain to idle.
    req = 4'b0000;
    pulse_done(1);
    repeat (5) @(posedge clk);
    #1;
    chk("idle_grant", grant, 4'b0000);
    chk("idle_busy", busy, 1'b0);
    chk("idle_select", select, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
